bus6502_xfer: RTL and testbench

Parametrised bus-cycle sequencer between the RV32 core's load/store/fetch unit and the external 6502-style 8-bit bus. It accepts one byte, halfword or word request at a time and performs it as consecutive little-endian byte cycles. It handles RDY stretching, AEC bus release, memory-lock and vector-pull signalling, and returns assembled, optionally sign-extended read data. It supersedes the fixed 32-bit memory state machine inside the core and adds width, alignment and RDY-policy modes.

---
 rtl/bus6502_xfer.sv | 191 +++++++++++++++++++
 tb/tb_bus6502_xfer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus6502_xfer.sv
// Bus-cycle sequencer: runs one byte/half/word request from the RV32 load/store/fetch
// unit as consecutive little-endian byte cycles on a 6502-style 8-bit bus.
// Handles RDY stretching, AEC release, memory lock, vector pull and read-data extension.
module bus6502_xfer #(
  parameter int unsigned DATA_BYTES   = 4,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned STRICT_ALIGN = 1,
  parameter int unsigned SYNC_RDY     = 1,
  parameter int unsigned RDY_WRITES   = 0
) (
  input  logic                    PH0IN,
  input  logic                    rst,
  // Core-side request/response
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [1:0]              req_size,
  input  logic                    req_we,
  input  logic                    req_signed,
  input  logic                    req_fetch,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  // External bus
  input  logic                    RDY,
  input  logic                    AEC,
  output logic [ADDR_W-1:0]       A_o,
  output logic                    A_oe,
  output logic                    RWn_oe,
  output logic                    RWn,
  output logic [7:0]              D_o,
  output logic                    D_oe,
  input  logic [7:0]              D_i,
  output logic                    SYNC,
  output logic                    MLn,
  output logic                    VPn
);

  localparam int unsigned DW = 8 * DATA_BYTES;
  // Lowest address of the six-byte vector area at the top of memory
  localparam logic [ADDR_W-1:0] VecBase = {ADDR_W{1'b1}} - ADDR_W'(5);

  typedef enum logic [1:0] {StIdle, StXfer, StResp} state_e;

  state_e          state_q;
  logic [1:0]      idx_q;
  logic [1:0]      last_q;
  logic            we_q;
  logic            signed_q;
  logic            rdy_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   data_q;

  logic [3:0]      req_n;
  logic [1:0]      req_mask;
  logic            req_err;
  logic            rdy_eff;
  logic            step;
  logic [ADDR_W-1:0] addr_inc;
  logic [DW-1:0]   wsh;
  logic [DW-1:0]   rdata_next;
  logic [DW-1:0]   rdata_ext;
  logic            msb;

  // Bus enables follow AEC directly; data is only driven during a write cycle
  assign A_oe   = AEC;
  assign RWn_oe = AEC;
  assign D_oe   = AEC & ~RWn;

  // Request decode: byte count, alignment mask and error classification
  always_comb begin
    req_n = 4'd1 << req_size;
    unique case (req_size)
      2'd0:    req_mask = 2'd0;
      2'd1:    req_mask = 2'd1;
      default: req_mask = 2'd3;
    endcase
    req_err = (32'(req_n) > DATA_BYTES) ||
              ((STRICT_ALIGN != 0) && ((req_addr[1:0] & req_mask) != 2'd0));
  end

  // Byte-cycle completion qualifier; writes may bypass RDY
  always_comb begin
    rdy_eff  = ((SYNC_RDY != 0) ? rdy_q : RDY) | ((RDY_WRITES == 0) && we_q);
    step     = (state_q == StXfer) && rdy_eff && AEC;
    addr_inc = A_o + ADDR_W'(1);
    wsh      = wdata_q >> 8;
  end

  // Merge the current read byte and extend the result above the last byte
  always_comb begin
    rdata_next = data_q;
    for (int b = 0; b < int'(DATA_BYTES); b++) begin
      if (b == int'(idx_q)) rdata_next[8*b +: 8] = D_i;
    end
    msb = 1'b0;
    for (int b = 0; b < int'(DATA_BYTES); b++) begin
      if (b == int'(last_q)) msb = rdata_next[8*b+7];
    end
    rdata_ext = '0;
    for (int b = 0; b < int'(DATA_BYTES); b++) begin
      if (b <= int'(last_q)) rdata_ext[8*b +: 8] = rdata_next[8*b +: 8];
      else                   rdata_ext[8*b +: 8] = {8{signed_q & msb}};
    end
  end

  // Sequencer FSM with registered bus and response outputs
  always_ff @(posedge PH0IN or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      last_q    <= '0;
      we_q      <= 1'b0;
      signed_q  <= 1'b0;
      rdy_q     <= 1'b0;
      wdata_q   <= '0;
      data_q    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      A_o       <= '0;
      RWn       <= 1'b1;
      D_o       <= '0;
      SYNC      <= 1'b0;
      MLn       <= 1'b1;
      VPn       <= 1'b1;
    end else begin
      rdy_q <= RDY;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            signed_q  <= req_signed;
            last_q    <= req_mask;
            idx_q     <= '0;
            wdata_q   <= req_wdata;
            data_q    <= '0;
            if (req_err) begin
              // No bus cycle: straight to an error response
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state_q <= StXfer;
              A_o     <= req_addr;
              RWn     <= ~req_we;
              D_o     <= req_wdata[7:0];
              SYNC    <= req_fetch;
              MLn     <= ~(req_we && (req_size != 2'd0));
              VPn     <= ~(~req_we && (req_addr >= VecBase));
            end
          end
        end
        StXfer: begin
          if (step) begin
            data_q <= rdata_next;
            idx_q  <= idx_q + 2'd1;
            if (idx_q == last_q) begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= we_q ? '0 : rdata_ext;
              RWn       <= 1'b1;
              SYNC      <= 1'b0;
              MLn       <= 1'b1;
              VPn       <= 1'b1;
            end else begin
              A_o     <= addr_inc;
              wdata_q <= wsh;
              D_o     <= wsh[7:0];
              VPn     <= ~(~we_q && (addr_inc >= VecBase));
            end
          end
        end
        StResp: begin
          state_q   <= StIdle;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bus6502_xfer.sv
// Directed bench for bus6502_xfer: u0 uses default parameters, u1 is a relaxed-alignment,
// RDY-stalls-writes variant. Request valids are separate, other inputs shared.
module tb_bus6502_xfer;

  logic        PH0IN = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic [15:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_we = 1'b0, req_signed = 1'b0, req_fetch = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        RDY = 1'b0, AEC = 1'b1;
  logic [7:0]  D_i = '0;

  logic        req_ready_0, rsp_valid_0, rsp_err_0, A_oe_0, RWn_oe_0, RWn_0, D_oe_0;
  logic        SYNC_0, MLn_0, VPn_0;
  logic [31:0] rsp_rdata_0;
  logic [15:0] A_o_0;
  logic [7:0]  D_o_0;
  logic        req_ready_1, rsp_valid_1, rsp_err_1, A_oe_1, RWn_oe_1, RWn_1, D_oe_1;
  logic        SYNC_1, MLn_1, VPn_1;
  logic [31:0] rsp_rdata_1;
  logic [15:0] A_o_1;
  logic [7:0]  D_o_1;

  int nvec = 0;
  int nerr = 0;

  always #5 PH0IN = ~PH0IN;

  bus6502_xfer u0 (
    .PH0IN(PH0IN), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready_0),
    .req_addr(req_addr), .req_size(req_size), .req_we(req_we), .req_signed(req_signed),
    .req_fetch(req_fetch), .req_wdata(req_wdata), .rsp_valid(rsp_valid_0),
    .rsp_err(rsp_err_0), .rsp_rdata(rsp_rdata_0), .RDY(RDY), .AEC(AEC), .A_o(A_o_0),
    .A_oe(A_oe_0), .RWn_oe(RWn_oe_0), .RWn(RWn_0), .D_o(D_o_0), .D_oe(D_oe_0),
    .D_i(D_i), .SYNC(SYNC_0), .MLn(MLn_0), .VPn(VPn_0)
  );

  bus6502_xfer #(.STRICT_ALIGN(0), .SYNC_RDY(1), .RDY_WRITES(1)) u1 (
    .PH0IN(PH0IN), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready_1),
    .req_addr(req_addr), .req_size(req_size), .req_we(req_we), .req_signed(req_signed),
    .req_fetch(req_fetch), .req_wdata(req_wdata), .rsp_valid(rsp_valid_1),
    .rsp_err(rsp_err_1), .rsp_rdata(rsp_rdata_1), .RDY(RDY), .AEC(AEC), .A_o(A_o_1),
    .A_oe(A_oe_1), .RWn_oe(RWn_oe_1), .RWn(RWn_1), .D_o(D_o_1), .D_oe(D_oe_1),
    .D_i(D_i), .SYNC(SYNC_1), .MLn(MLn_1), .VPn(VPn_1)
  );

  task automatic tick();
    @(posedge PH0IN);
    #1;
  endtask

  // Present a request in cycle 0; returns #1 into cycle 1
  task automatic issue(input bit which, input logic [15:0] a, input logic [1:0] sz,
                       input logic we, input logic sg, input logic fe, input logic [31:0] wd);
    req_addr = a; req_size = sz; req_we = we; req_signed = sg; req_fetch = fe; req_wdata = wd;
    if (which) req_valid1 = 1'b1;
    else       req_valid0 = 1'b1;
    tick();
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    nvec++; if (req_ready_0 !== 1'b1) begin nerr++; $display("FAIL reset req_ready: got %b want 1", req_ready_0); end
    nvec++; if (rsp_valid_0 !== 1'b0) begin nerr++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid_0); end
    nvec++; if (rsp_rdata_0 !== 32'h0) begin nerr++; $display("FAIL reset rsp_rdata: got %h want 0", rsp_rdata_0); end
    nvec++; if (A_o_0 !== 16'h0) begin nerr++; $display("FAIL reset A_o: got %h want 0000", A_o_0); end
    nvec++; if ({RWn_0, SYNC_0, MLn_0, VPn_0, D_oe_0} !== 5'b10110)
      begin nerr++; $display("FAIL reset bus ctl: got %b want 10110", {RWn_0, SYNC_0, MLn_0, VPn_0, D_oe_0}); end
    nvec++; if (D_o_0 !== 8'h00) begin nerr++; $display("FAIL reset D_o: got %h want 00", D_o_0); end
    rst = 1'b0;
    RDY = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_word_read();
    logic [7:0] bytes [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    logic [15:0] ea;
    issue(1'b0, 16'h1234, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      ea = 16'(16'h1234 + k);
      nvec++; if (A_o_0 !== ea) begin nerr++; $display("FAIL word_read A_o c%0d: got %h want %h", k + 1, A_o_0, ea); end
      nvec++; if (RWn_0 !== 1'b1 || rsp_valid_0 !== 1'b0)
        begin nerr++; $display("FAIL word_read ctl c%0d: got RWn=%b rsp=%b want 1 0", k + 1, RWn_0, rsp_valid_0); end
      D_i = bytes[k];
      tick();
    end
    nvec++; if (rsp_valid_0 !== 1'b1) begin nerr++; $display("FAIL word_read rsp_valid c5: got %b want 1", rsp_valid_0); end
    nvec++; if (rsp_rdata_0 !== 32'h12345678) begin nerr++; $display("FAIL word_read rdata: got %h want 12345678", rsp_rdata_0); end
    nvec++; if (req_ready_0 !== 1'b0) begin nerr++; $display("FAIL word_read req_ready in resp: got %b want 0", req_ready_0); end
    tick();
    nvec++; if (rsp_valid_0 !== 1'b0 || req_ready_0 !== 1'b1)
      begin nerr++; $display("FAIL word_read after resp: got rsp=%b rdy=%b want 0 1", rsp_valid_0, req_ready_0); end
  endtask

  task automatic test_signed_byte();
    issue(1'b0, 16'hFFFC, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0);
    nvec++; if (VPn_0 !== 1'b0 || A_o_0 !== 16'hFFFC)
      begin nerr++; $display("FAIL sbyte vector pull: got VPn=%b A=%h want 0 fffc", VPn_0, A_o_0); end
    D_i = 8'h80;
    tick();
    nvec++; if (rsp_valid_0 !== 1'b1 || rsp_err_0 !== 1'b0)
      begin nerr++; $display("FAIL sbyte rsp: got v=%b e=%b want 1 0", rsp_valid_0, rsp_err_0); end
    nvec++; if (rsp_rdata_0 !== 32'hFFFFFF80) begin nerr++; $display("FAIL sbyte rdata: got %h want ffffff80", rsp_rdata_0); end
    nvec++; if (VPn_0 !== 1'b1) begin nerr++; $display("FAIL sbyte VPn idle: got %b want 1", VPn_0); end
    tick();
  endtask

  task automatic test_write_no_stall();
    RDY = 1'b0;
    issue(1'b0, 16'h0200, 2'd1, 1'b1, 1'b0, 1'b0, 32'h0000BEEF);
    nvec++; if ({A_o_0, D_o_0} !== {16'h0200, 8'hEF})
      begin nerr++; $display("FAIL wr c1 addr/data: got %h %h want 0200 ef", A_o_0, D_o_0); end
    nvec++; if ({RWn_0, MLn_0, D_oe_0} !== 3'b001)
      begin nerr++; $display("FAIL wr c1 ctl: got %b want 001", {RWn_0, MLn_0, D_oe_0}); end
    tick();
    nvec++; if ({A_o_0, D_o_0} !== {16'h0201, 8'hBE})
      begin nerr++; $display("FAIL wr c2 addr/data: got %h %h want 0201 be", A_o_0, D_o_0); end
    nvec++; if ({RWn_0, MLn_0} !== 2'b00) begin nerr++; $display("FAIL wr c2 ctl: got %b want 00", {RWn_0, MLn_0}); end
    tick();
    nvec++; if (rsp_valid_0 !== 1'b1 || rsp_rdata_0 !== 32'h0)
      begin nerr++; $display("FAIL wr c3 rsp: got v=%b d=%h want 1 0", rsp_valid_0, rsp_rdata_0); end
    nvec++; if ({RWn_0, MLn_0, D_oe_0} !== 3'b110)
      begin nerr++; $display("FAIL wr c3 idle ctl: got %b want 110", {RWn_0, MLn_0, D_oe_0}); end
    RDY = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_misalign();
    issue(1'b0, 16'h0002, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0);
    nvec++; if ({rsp_valid_0, rsp_err_0} !== 2'b11)
      begin nerr++; $display("FAIL misalign rsp: got %b want 11", {rsp_valid_0, rsp_err_0}); end
    nvec++; if (A_o_0 !== 16'h0201 || RWn_0 !== 1'b1)
      begin nerr++; $display("FAIL misalign bus: got A=%h RWn=%b want 0201 1", A_o_0, RWn_0); end
    tick();
    nvec++; if ({rsp_valid_0, rsp_err_0, req_ready_0} !== 3'b001)
      begin nerr++; $display("FAIL misalign end: got %b want 001", {rsp_valid_0, rsp_err_0, req_ready_0}); end
    issue(1'b0, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b0, 32'h0);
    nvec++; if ({rsp_valid_0, rsp_err_0, rsp_rdata_0} !== {2'b11, 32'h0})
      begin nerr++; $display("FAIL oversize rsp: got %b%b %h want 11 0", rsp_valid_0, rsp_err_0, rsp_rdata_0); end
    tick();
  endtask

  task automatic test_write_stall();
    RDY = 1'b0;
    issue(1'b1, 16'h0200, 2'd1, 1'b1, 1'b0, 1'b0, 32'h0000BEEF);
    for (int c = 1; c <= 5; c++) begin
      if (c == 4) RDY = 1'b1;
      nvec++; if ({A_o_1, D_o_1, RWn_1} !== {16'h0200, 8'hEF, 1'b0})
        begin nerr++; $display("FAIL wstall c%0d byte0: got %h %h %b want 0200 ef 0", c, A_o_1, D_o_1, RWn_1); end
      tick();
    end
    nvec++; if ({A_o_1, D_o_1, MLn_1, rsp_valid_1} !== {16'h0201, 8'hBE, 2'b00})
      begin nerr++; $display("FAIL wstall c6: got %h %h %b %b want 0201 be 0 0", A_o_1, D_o_1, MLn_1, rsp_valid_1); end
    tick();
    nvec++; if (rsp_valid_1 !== 1'b1) begin nerr++; $display("FAIL wstall rsp c7: got %b want 1", rsp_valid_1); end
    tick();
  endtask

  task automatic test_wrap();
    logic [15:0] ea [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    logic [7:0]  db [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic        ev [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    issue(1'b1, 16'hFFFE, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      nvec++; if ({A_o_1, VPn_1} !== {ea[k], ev[k]})
        begin nerr++; $display("FAIL wrap c%0d: got %h VPn=%b want %h %b", k + 1, A_o_1, VPn_1, ea[k], ev[k]); end
      D_i = db[k];
      tick();
    end
    nvec++; if ({rsp_valid_1, rsp_err_1, rsp_rdata_1} !== {2'b10, 32'h44332211})
      begin nerr++; $display("FAIL wrap rsp: got %b%b %h want 10 44332211", rsp_valid_1, rsp_err_1, rsp_rdata_1); end
    tick();
  endtask

  task automatic test_fetch_aec();
    logic [15:0] ea [6] = '{16'h0400, 16'h0401, 16'h0401, 16'h0401, 16'h0402, 16'h0403};
    logic        ae [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    issue(1'b0, 16'h0400, 2'd2, 1'b0, 1'b0, 1'b1, 32'h0);
    for (int c = 0; c < 6; c++) begin
      AEC = ae[c];
      D_i = 8'(ea[c][7:0] + 8'h10);
      #1;
      nvec++; if ({A_o_0, SYNC_0} !== {ea[c], 1'b1})
        begin nerr++; $display("FAIL fetch c%0d: got %h SYNC=%b want %h 1", c + 1, A_o_0, SYNC_0, ea[c]); end
      nvec++; if ({A_oe_0, RWn_oe_0, D_oe_0, rsp_valid_0} !== {ae[c], ae[c], 2'b00})
        begin nerr++; $display("FAIL fetch oe c%0d: got %b want %b%b00", c + 1, {A_oe_0, RWn_oe_0, D_oe_0, rsp_valid_0}, ae[c], ae[c]); end
      tick();
    end
    nvec++; if ({rsp_valid_0, SYNC_0, rsp_rdata_0} !== {2'b10, 32'h13121110})
      begin nerr++; $display("FAIL fetch rsp c7: got %b%b %h want 10 13121110", rsp_valid_0, SYNC_0, rsp_rdata_0); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    issue(1'b0, 16'h0500, 2'd2, 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    nvec++; if ({A_o_0, SYNC_0} !== {16'h0501, 1'b1})
      begin nerr++; $display("FAIL rstmid pre: got %h %b want 0501 1", A_o_0, SYNC_0); end
    rst = 1'b1;
    #1;
    nvec++; if ({A_o_0, SYNC_0, RWn_0, MLn_0, VPn_0} !== {16'h0000, 4'b0111})
      begin nerr++; $display("FAIL rstmid async bus: got %h %b want 0000 0111", A_o_0, {SYNC_0, RWn_0, MLn_0, VPn_0}); end
    nvec++; if ({req_ready_0, rsp_valid_0} !== 2'b10)
      begin nerr++; $display("FAIL rstmid async rsp: got %b want 10", {req_ready_0, rsp_valid_0}); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid_0 !== 1'b0) seen++;
      tick();
    end
    nvec++; if (seen != 0) begin nerr++; $display("FAIL rstmid no response: got %0d pulses want 0", seen); end
    nvec++; if (req_ready_0 !== 1'b1) begin nerr++; $display("FAIL rstmid idle ready: got %b want 1", req_ready_0); end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_signed_byte();
    test_write_no_stall();
    test_misalign();
    test_write_stall();
    test_wrap();
    test_fetch_aec();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
